// File: rtl/score_digits_ctrl.sv
// score_digits_ctrl
//   Drives one shared digit renderer across a row of four decimal slots that
//   display a binary score. The score is converted to BCD by an iterative
//   shift-add-3 engine. The finished digits are copied into the display
//   register in a single cycle, so a frame never shows a partial conversion.
//
// Ports
//   clk             pixel clock
//   resetN          asynchronous active-low reset
//   pixelX/pixelY   current scan position (11 bits each)
//   score/update    score to show; sampled when update is high for one cycle
//   digit           BCD value for the renderer (0 when not drawing)
//   offsetX/offsetY position inside the 16x32 slot (0 when not drawing)
//   InsideRectangle pixel lies in a drawn (non-blanked) slot
//   busy            conversion in progress
module score_digits_ctrl #(
  parameter logic [10:0] TOP_LEFT_X    = 11'd500,
  parameter logic [10:0] TOP_LEFT_Y    = 11'd20,
  parameter logic        BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [13:0] score,
  input  logic        update,
  output logic [3:0]  digit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        busy
);

  localparam logic [3:0] LAST_SHIFT = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t      state, state_nxt;
  logic        load, shift, commit, use_pend;
  logic [13:0] load_val;
  logic [13:0] bin_r;
  logic [15:0] bcd_r;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_r;
  logic [15:0] disp_r;
  logic        pend_vld;
  logic [13:0] pend_val;

  function automatic logic [13:0] sat_score(input logic [13:0] s);
    return (s > 14'd9999) ? 14'd9999 : s;
  endfunction

  // Add 3 to every nibble >= 5 so the following left shift carries into the
  // next decimal digit instead of producing a value above 9.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    use_pend  = 1'b0;
    case (state)
      S_IDLE: begin
        if (update) begin
          load      = 1'b1;
          state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        shift = 1'b1;
        if (cnt_r == LAST_SHIFT) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        commit = 1'b1;
        // An update landing in COMMIT is newer than any held value.
        if (update) begin
          load      = 1'b1;
          state_nxt = S_CONVERT;
        end else if (pend_vld) begin
          load      = 1'b1;
          use_pend  = 1'b1;
          state_nxt = S_CONVERT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign load_val = use_pend ? pend_val : sat_score(score);
  assign bcd_adj  = add3_nibbles(bcd_r);
  assign busy     = (state != S_IDLE);

  // Shift engine: working registers need no reset, IDLE ignores them.
  always_ff @(posedge clk) begin
    if (load) begin
      bin_r <= load_val;
      bcd_r <= 16'd0;
      cnt_r <= 4'd0;
    end else if (shift) begin
      bcd_r <= {bcd_adj[14:0], bin_r[13]};
      bin_r <= {bin_r[12:0], 1'b0};
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Display and pending registers: last update while converting wins.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      disp_r   <= 16'd0;
      pend_vld <= 1'b0;
      pend_val <= 14'd0;
    end else begin
      if (commit) disp_r <= bcd_r;
      if (load) begin
        pend_vld <= 1'b0;
      end else if (update && state == S_CONVERT) begin
        pend_vld <= 1'b1;
        pend_val <= sat_score(score);
      end
    end
  end

  // ---------------- pixel stage p0 (combinational select) ----------------
  logic [5:0]  rel_x_p0;
  logic [4:0]  rel_y_p0;
  logic        in_win_p0;
  logic [1:0]  slot_p0;
  logic [3:0]  nib_p0;
  logic        blank_p0;
  logic        draw_p0;

  // Only the low bits of the offsets are ever used, so subtract on those.
  assign rel_x_p0  = pixelX[5:0] - TOP_LEFT_X[5:0];
  assign rel_y_p0  = pixelY[4:0] - TOP_LEFT_Y[4:0];
  // Extended to 12 bits so TOP_LEFT+size cannot wrap.
  assign in_win_p0 = ({1'b0, pixelX} >= {1'b0, TOP_LEFT_X}) &&
                     ({1'b0, pixelX} <  ({1'b0, TOP_LEFT_X} + 12'd64)) &&
                     ({1'b0, pixelY} >= {1'b0, TOP_LEFT_Y}) &&
                     ({1'b0, pixelY} <  ({1'b0, TOP_LEFT_Y} + 12'd32));
  assign slot_p0   = rel_x_p0[5:4];

  always_comb begin
    nib_p0   = 4'd0;
    blank_p0 = 1'b0;
    case (slot_p0)
      2'd0: begin nib_p0 = disp_r[15:12]; blank_p0 = (disp_r[15:12] == 4'd0); end
      2'd1: begin nib_p0 = disp_r[11:8];  blank_p0 = (disp_r[15:8]  == 8'd0); end
      2'd2: begin nib_p0 = disp_r[7:4];   blank_p0 = (disp_r[15:4]  == 12'd0); end
      default: begin nib_p0 = disp_r[3:0]; blank_p0 = 1'b0; end
    endcase
  end

  assign draw_p0 = in_win_p0 && !(BLANK_LEADING && blank_p0);

  // ---------------- pixel stage p1 (registered outputs) ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit           <= 4'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end else if (draw_p0) begin
      digit           <= nib_p0;
      offsetX         <= {7'd0, rel_x_p0[3:0]};
      offsetY         <= {6'd0, rel_y_p0};
      InsideRectangle <= 1'b1;
    end else begin
      digit           <= 4'd0;
      offsetX         <= 11'd0;
      offsetY         <= 11'd0;
      InsideRectangle <= 1'b0;
    end
  end

endmodule
